// File: rtl/gate_reduce_pkg.sv
// Shared types and the lane-reduction function for the gate_reduce_pipe slice.
// reduce_lanes works on a maximal bus so callers of any WIDTH/LANES can share it.
package gate_reduce_pkg;

  typedef enum logic [1:0] {
    GM_AND  = 2'b00,
    GM_OR   = 2'b01,
    GM_XOR  = 2'b10,
    GM_NAND = 2'b11
  } gate_mode_e;

  localparam int unsigned MAX_W     = 32;
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned BUS_W     = MAX_W * MAX_LANES;

  // Left-to-right bitwise reduction; NAND is the inverted full AND, not a chained NAND.
  function automatic logic [MAX_W-1:0] reduce_lanes(input logic [BUS_W-1:0] data,
                                                    input gate_mode_e       mode,
                                                    input int unsigned      width,
                                                    input int unsigned      lanes);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] lane;
    logic [MAX_W-1:0] acc;
    mask = (width >= MAX_W) ? '1 : MAX_W'((64'(1) << width) - 64'(1));
    acc  = MAX_W'(data) & mask;
    lane = '0;
    for (int unsigned k = 1; k < MAX_LANES; k++) begin
      if (k < lanes) begin
        lane = MAX_W'(data >> (k * width)) & mask;
        case (mode)
          GM_AND, GM_NAND: acc = acc & lane;
          GM_OR:           acc = acc | lane;
          GM_XOR:          acc = acc ^ lane;
          default:         acc = acc;
        endcase
      end
    end
    if (mode == GM_NAND) acc = ~acc & mask;
    return acc;
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One-entry valid/ready register; accepts whenever empty or being drained.
module pipe_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready_c = ~out_valid | out_ready;

  // Payload only loads on a real handshake so idle-cycle data never enters the stage.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline reducing LANES operand vectors with a selectable gate.
// Stage 1 holds raw operands and mode; stage 2 holds the reduced result and flags.
module gate_reduce_pipe
  import gate_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_q,
  output logic                   out_any,
  output logic                   out_all,
  output logic [CNT_W-1:0]       count
);

  localparam int unsigned DATA_W = LANES * WIDTH;
  localparam int unsigned S1_W   = DATA_W + 2;
  localparam int unsigned S2_W   = WIDTH + 2;

  logic              s1_ready_c;
  logic              s1_valid;
  logic              s2_ready_c;
  logic [S1_W-1:0]   s1_payload;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        s1_mode;
  logic [WIDTH-1:0]  red_q;
  logic [S2_W-1:0]   s2_payload;

  pipe_slice #(.W(S1_W)) u_s1 (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_valid   (in_valid),
    .in_ready_c (s1_ready_c),
    .in_data    ({in_mode, in_data}),
    .out_valid  (s1_valid),
    .out_ready  (s2_ready_c),
    .out_data   (s1_payload)
  );

  assign {s1_mode, s1_data} = s1_payload;
  assign red_q = WIDTH'(reduce_lanes(BUS_W'(s1_data), gate_mode_e'(s1_mode), WIDTH, LANES));

  pipe_slice #(.W(S2_W)) u_s2 (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_valid   (s1_valid),
    .in_ready_c (s2_ready_c),
    .in_data    ({red_q, |red_q, &red_q}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (s2_payload)
  );

  assign {out_q, out_any, out_all} = s2_payload;

  // Held low while in reset so nothing looks accepted before the pipe is live.
  assign in_ready = s1_ready_c & aresetn;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (out_valid && out_ready) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
